multiport_register_file: RTL and testbench

Parametrised general-purpose register file for the pipelined datapath. It supersedes the fixed two-read/one-write file and provides:
- a configurable number of read ports;
- same-cycle write-to-read bypass;
- a hardware clear sequencer that zeroes every entry after reset or on request, with a ready indication to the pipeline.

Reads are combinational. Writes commit on the rising edge of clk.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_clear_ctrl.sv | 60 ++++++
 rtl/multiport_register_file.sv | 86 ++++++++
 tb/tb_multiport_register_file.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// The optional feature macro REGFILE_ZERO_REG_EN is consumed by multiport_register_file.
package regfile_pkg;

    localparam int unsigned RF_DEF_WIDTH    = 32;
    localparam int unsigned RF_DEF_ADDR     = 5;
    localparam int unsigned RF_DEF_DEPTH    = 32;
    localparam int unsigned RF_DEF_RD_PORTS = 2;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Bit offset of a port's field inside a packed multi-port bus.
    function automatic int unsigned port_offset(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: sweeps every entry to zero after reset or on request,
// then reports ready. Holds the FSM and the sweep address counter.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH     = RF_DEF_DEPTH,
    parameter int unsigned ADDR_SIZE = RF_DEF_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req_i,
    output logic                 clear_we_o,
    output logic [ADDR_SIZE-1:0] clear_addr_o,
    output logic                 ready_o
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

    rf_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_CLEAR: begin
                // Counter parks on the last entry rather than wrapping.
                if (cnt_q == LAST_ADDR) begin
                    state_d = RF_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_SIZE'(1);
                end
            end
            RF_IDLE: begin
                if (clear_req_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    always_comb begin
        ready_o      = (state_q == RF_IDLE);
        clear_we_o   = (state_q == RF_CLEAR);
        clear_addr_o = cnt_q;
    end

endmodule

// File: rtl/multiport_register_file.sv
// Register file with N combinational read ports, same-cycle write bypass and a
// hardware clear sweep. Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned REG_WIDTH    = RF_DEF_WIDTH,
    parameter int unsigned REG_DEPTH    = RF_DEF_DEPTH,
    parameter int unsigned ADDR_SIZE    = RF_DEF_ADDR,
    parameter int unsigned NUM_RD_PORTS = RF_DEF_RD_PORTS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              reg_write,
    input  logic [ADDR_SIZE-1:0]              write_register,
    input  logic [REG_WIDTH-1:0]              write_data,
    input  logic [NUM_RD_PORTS*ADDR_SIZE-1:0] read_register,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0] read_data,
    input  logic                              clear_req,
    output logic                              ready
);

    logic                 clear_we;
    logic [ADDR_SIZE-1:0] clear_addr;
    logic                 user_we;
    logic                 wr_addr_ok;

    logic [REG_WIDTH-1:0] regs_q [REG_DEPTH];

    regfile_clear_ctrl #(
        .DEPTH     (REG_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_clear_ctrl (
        .clk          (clk),
        .rst          (rst),
        .clear_req_i  (clear_req),
        .clear_we_o   (clear_we),
        .clear_addr_o (clear_addr),
        .ready_o      (ready)
    );

`ifdef REGFILE_ZERO_REG_EN
    assign wr_addr_ok = (write_register != '0);
`else
    assign wr_addr_ok = 1'b1;
`endif

    // A write coinciding with a clear request is dropped: the sweep wins.
    assign user_we = ready && reg_write && !clear_req && wr_addr_ok;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            regs_q[clear_addr] <= '0;
        end else if (user_we) begin
            regs_q[write_register] <= write_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
            logic [ADDR_SIZE-1:0] raddr;
            logic                 bypass_hit;
            logic [REG_WIDTH-1:0] rdata;

            assign raddr      = read_register[port_offset(gi, ADDR_SIZE) +: ADDR_SIZE];
            assign bypass_hit = ready && reg_write && (write_register == raddr);

            always_comb begin
                rdata = regs_q[raddr];
                if (!ready) begin
                    rdata = '0;
                end else if (bypass_hit) begin
                    rdata = write_data;
                end
`ifdef REGFILE_ZERO_REG_EN
                if (raddr == '0) begin
                    rdata = '0;
                end
`endif
            end

            assign read_data[port_offset(gi, REG_WIDTH) +: REG_WIDTH] = rdata;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: directed steps plus random traffic against an array model.
module tb_multiport_register_file;

    localparam int W = 32;
    localparam int A = 5;
    localparam int D = 32;
    localparam int P = 2;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           reg_write;
    logic [A-1:0]   write_register;
    logic [W-1:0]   write_data;
    logic [P*A-1:0] read_register;
    logic [P*W-1:0] read_data;
    logic           clear_req;
    logic           ready;

    multiport_register_file #(
        .REG_WIDTH    (W),
        .REG_DEPTH    (D),
        .ADDR_SIZE    (A),
        .NUM_RD_PORTS (P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .read_register  (read_register),
        .read_data      (read_data),
        .clear_req      (clear_req),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents and remaining cycles of the current sweep.
    logic [W-1:0] mem [D];
    int           sweep_left;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) mem[i] = '0;
        sweep_left = D;
    endtask

    function automatic logic [W-1:0] exp_read(input logic rdy, input logic we, input logic [A-1:0] wa,
                                              input logic [W-1:0] wd, input logic [A-1:0] ra);
        if (!rdy) return '0;
        if (ZERO_REG && ra == '0) return '0;
        if (we && wa == ra) return wd;
        return mem[ra];
    endfunction

    // One clock cycle: drive, check combinational outputs mid-cycle, commit model on the edge.
    task automatic cyc(input logic we, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic [A-1:0] r0, input logic [A-1:0] r1, input logic cr);
        logic rdy_m;
        reg_write      = we;
        write_register = wa;
        write_data     = wd;
        read_register  = {r1, r0};
        clear_req      = cr;
        @(negedge clk);
        rdy_m = (sweep_left == 0);
        chk("ready", {31'b0, ready}, {31'b0, rdy_m});
        chk("rd_port0", read_data[0 +: W], exp_read(rdy_m, we, wa, wd, r0));
        chk("rd_port1", read_data[W +: W], exp_read(rdy_m, we, wa, wd, r1));
        $display("cyc t=%0t rdy=%0b we=%0b wa=%0d wd=%h ra0=%0d ra1=%0d clr=%0b rd0=%h rd1=%h",
                 $time, ready, we, wa, wd, r0, r1, cr, read_data[0 +: W], read_data[W +: W]);
        @(posedge clk);
        if (rdy_m) begin
            if (cr) model_clear();
            else if (we && !(ZERO_REG && wa == '0)) mem[wa] = wd;
        end else begin
            sweep_left--;
        end
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        model_clear();
    endtask

    // Idle cycles until ready rises, returning the number of not-ready cycles (bounded).
    task automatic wait_sweep(input logic we, input logic [A-1:0] wa, input logic [W-1:0] wd, output int n);
        n = 0;
        while (!ready && n < 200) begin
            cyc(we, wa, wd, A'(n), A'(D - 1 - n), 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        reg_write = 1'b0; write_register = '0; write_data = '0;
        read_register = '0; clear_req = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_rd0", read_data[0 +: W], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Power-up sweep must take exactly D cycles.
        wait_sweep(1'b0, '0, '0, n);
        chk("sweep_len_reset", 32'(n), 32'(D));
        for (int i = 0; i < D / 2; i++) cyc(1'b0, '0, '0, A'(i), A'(D - 1 - i), 1'b0);

        // Write then read on both ports.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);

        // Bypass on port 1, port 0 reads a neighbour.
        cyc(1'b1, 5'd7, 32'h12345678, 5'd6, 5'd7, 1'b0);
        cyc(1'b0, '0, '0, 5'd7, 5'd6, 1'b0);

        // Fill, then clear request with a coincident write that must be dropped.
        for (int i = 1; i < D; i++) cyc(1'b1, A'(i), W'(i), A'(i - 1), A'(i), 1'b0);
        cyc(1'b1, 5'd3, 32'hFF, 5'd3, 5'd4, 1'b1);
        wait_sweep(1'b1, 5'd9, 32'hAAAA, n);
        chk("sweep_len_req", 32'(n), 32'(D));
        for (int i = 0; i < D / 2; i++) cyc(1'b0, '0, '0, A'(i), A'(D - 1 - i), 1'b0);

        // Reset ten cycles into a requested sweep restarts it.
        cyc(1'b0, '0, '0, 5'd1, 5'd2, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 5'd9, 32'hAAAA, 5'd9, A'(i), 1'b0);
        rst_pulse();
        wait_sweep(1'b1, 5'd9, 32'hAAAA, n);
        chk("sweep_len_rst", 32'(n), 32'(D));
        cyc(1'b0, '0, '0, 5'd9, 5'd3, 1'b0);

        // Register 0 write with bypass, then plain read.
        cyc(1'b1, 5'd0, 32'h55, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);

        // Random traffic, with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            logic [A-1:0] ra0;
            ra0 = A'($urandom_range(0, D - 1));
            cyc(1'($urandom_range(0, 1)), A'($urandom_range(0, D - 1)), W'($urandom),
                ra0, ($urandom_range(0, 3) == 0) ? ra0 : A'($urandom_range(0, D - 1)),
                ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
